clk_switch_ctrl: RTL and testbench

// - Control end of the glitch-free clock mux: owns its `select` input and sequences every switch.
// - Accepts switch requests over a valid/ready handshake on the system clock.
// - Drives the mux select, then waits until the mux enable feedback shows the old clock gated off and the new clock gated on.
// - Holds select stable for a minimum time and pulses `done`. Only one switch is in flight at a time.

---
 rtl/clk_sw_pkg.sv | 6 +
 rtl/clk_switch_ctrl_if.sv | 8 +
 rtl/cdc_sync_bit.sv | 21 ++
 rtl/clk_switch_ctrl.sv | 127 ++++++++++++
 tb/tb_clk_switch_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_sw_pkg.sv
// clk_sw_pkg: shared state encoding and select constants for the clock switch controller
package clk_sw_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_OFF, WAIT_ON, HOLD} clk_sw_state_t;
    localparam logic SEL_CLK0 = 1'b0;
    localparam logic SEL_CLK1 = 1'b1;
endpackage

// File: rtl/clk_switch_ctrl_if.sv
// clk_switch_ctrl_if: valid/ready switch-request channel into the clock switch controller
interface clk_switch_ctrl_if;
    logic req_valid;
    logic req_sel;
    logic req_ready;
    modport master (output req_valid, output req_sel, input req_ready);
    modport slave (input req_valid, input req_sel, output req_ready);
endinterface

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: STAGES-deep flop chain bringing an asynchronous bit into the clk domain
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q, sync_d;

    // shift the async bit one stage further each cycle
    always_comb sync_d = {sync_q[STAGES-2:0], d};

    // chain registers, cleared to 0 by reset
    always_ff @(posedge clk)
        if (!rst_n) sync_q <= '0;
        else sync_q <= sync_d;

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: sequences glitch-free clock mux switches; optional watchdog via CLK_SW_TIMEOUT_EN
module clk_switch_ctrl
    import clk_sw_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    clk_switch_ctrl_if.slave    req,
    output logic                sel_out,
    input  logic                en0_fb,
    input  logic                en1_fb,
    output logic                cur_sel,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                fault
);
    clk_sw_state_t state_q, state_d;
    logic          sel_q, sel_d, cur_q, cur_d, done_q, done_d, fault_q, fault_d;
    logic [7:0]    hold_q, hold_d;
    logic [1:0]    en_s;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync0 (.clk(clk), .rst_n(rst_n), .d(en0_fb), .q(en_s[0]));
    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync1 (.clk(clk), .rst_n(rst_n), .d(en1_fb), .q(en_s[1]));

`ifdef CLK_SW_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    // switch sequencing: drive select, wait old-off then new-on, hold, then commit
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cur_d   = cur_q;
        done_d  = 1'b0;
        hold_d  = hold_q;
        fault_d = fault_q | (en_s[0] & en_s[1]);
`ifdef CLK_SW_TIMEOUT_EN
        err_d   = 1'b0;
        tmo_d   = (tmo_q != TW'(TIMEOUT_CYCLES)) ? tmo_q + TW'(1) : tmo_q;
`endif
        case (state_q)
            IDLE:
                if (req.req_valid) begin
                    if (req.req_sel == cur_q) done_d = 1'b1;
                    else begin
                        sel_d   = req.req_sel;
                        state_d = WAIT_OFF;
`ifdef CLK_SW_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            WAIT_OFF:
                if (!en_s[cur_q]) begin
                    state_d = WAIT_ON;
`ifdef CLK_SW_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            WAIT_ON:
                if (en_s[sel_q]) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            HOLD:
                if (hold_q == 8'(HOLD_CYCLES - 1)) begin
                    cur_d   = sel_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else hold_d = hold_q + 8'd1;
        endcase
`ifdef CLK_SW_TIMEOUT_EN
        // a stuck wait abandons the switch but still commits to the driven select
        if ((state_q == WAIT_OFF || state_q == WAIT_ON) && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            cur_d   = sel_q;
            err_d   = 1'b1;
        end
`endif
    end

    // state and output registers; reset returns to clk0 select
    always_ff @(posedge clk)
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= SEL_CLK0;
            cur_q   <= SEL_CLK0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cur_q   <= cur_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            hold_q  <= hold_d;
        end

`ifdef CLK_SW_TIMEOUT_EN
    // watchdog counter and error pulse
    always_ff @(posedge clk)
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign req.req_ready = (state_q == IDLE);
    assign sel_out       = sel_q;
    assign cur_sel       = cur_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign fault         = fault_q;
endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: directed self-checking bench for clk_switch_ctrl
module tb_clk_switch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en0_fb = 1'b1;
    logic en1_fb = 1'b0;
    logic sel_out, cur_sel, busy, done, err, fault;
    int   errors = 0;
    int   checks = 0;

    clk_switch_ctrl_if rif ();

    clk_switch_ctrl #(.SYNC_STAGES(2), .HOLD_CYCLES(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(rif),
        .sel_out(sel_out), .en0_fb(en0_fb), .en1_fb(en1_fb),
        .cur_sel(cur_sel), .busy(busy), .done(done), .err(err), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rif.req_valid = 1'b0;
        rif.req_sel = 1'b0;
        rst_n = 1'b0;
        en0_fb = 1'b1;
        en1_fb = 1'b0;
        repeat (3) tick();
        checks++;
        if ({sel_out, cur_sel, rif.req_ready, busy, done, err, fault} !== 7'b0010000) begin
            errors++;
            $display("FAIL reset_state: got %b need 0010000", {sel_out, cur_sel, rif.req_ready, busy, done, err, fault});
        end
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_same_sel();
        rif.req_valid = 1'b1;
        rif.req_sel = 1'b0;
        tick();
        rif.req_valid = 1'b0;
        checks++;
        if ({done, busy, sel_out} !== 3'b100) begin
            errors++;
            $display("FAIL same_sel_done: got done/busy/sel=%b need 100", {done, busy, sel_out});
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL same_sel_pulse: done=%b need 0", done);
        end
    endtask

    task automatic test_switch();
        int done_at = -1;
        int done_cnt = 0;
        logic cur_at_done = 1'b0;
        logic sel_bad = 1'b0;
        logic fault_seen = 1'b0;
        rif.req_valid = 1'b1;
        rif.req_sel = 1'b1;
        tick();
        rif.req_valid = 1'b0;
        checks++;
        if ({sel_out, busy, cur_sel, rif.req_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL switch_accept: got sel/busy/cur/ready=%b need 1100", {sel_out, busy, cur_sel, rif.req_ready});
        end
        for (int k = 2; k <= 30; k++) begin
            tick();
            if (k == 3) en0_fb = 1'b0;
            if (k == 6) en1_fb = 1'b1;
            if (sel_out !== 1'b1) sel_bad = 1'b1;
            if (fault) fault_seen = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    cur_at_done = cur_sel;
                end
            end
        end
        checks++;
        if (done_at != 17) begin
            errors++;
            $display("FAIL switch_latency: done at cycle %0d need 17", done_at);
        end
        checks++;
        if (done_cnt != 1 || cur_at_done !== 1'b1) begin
            errors++;
            $display("FAIL switch_commit: dones=%0d cur_sel=%b need 1 and 1", done_cnt, cur_at_done);
        end
        checks++;
        if (sel_bad || fault_seen) begin
            errors++;
            $display("FAIL switch_stable: sel_dropped=%b fault=%b need 0 0", sel_bad, fault_seen);
        end
    endtask

    task automatic test_busy_ignore();
        int done_at = -1;
        int done_cnt = 0;
        logic sel_bad = 1'b0;
        rif.req_valid = 1'b1;
        rif.req_sel = 1'b0;
        tick();
        rif.req_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) tick();
            if (k == 3) en1_fb = 1'b0;
            if (k == 6) en0_fb = 1'b1;
            if (k == 8) begin
                rif.req_valid = 1'b1;
                rif.req_sel = 1'b1;
            end
            if (k == 9) rif.req_valid = 1'b0;
            if (sel_out !== 1'b0) sel_bad = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        checks++;
        if (sel_bad) begin
            errors++;
            $display("FAIL busy_ignore_sel: sel_out left 0 while busy");
        end
        checks++;
        if (done_cnt != 1 || done_at != 17) begin
            errors++;
            $display("FAIL busy_ignore_done: dones=%0d at %0d need 1 at 17", done_cnt, done_at);
        end
        checks++;
        if (cur_sel !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_end: cur_sel=%b busy=%b need 0 0", cur_sel, busy);
        end
    endtask

    task automatic test_reset_mid();
        rif.req_valid = 1'b1;
        rif.req_sel = 1'b1;
        tick();
        rif.req_valid = 1'b0;
        for (int k = 2; k <= 7; k++) begin
            tick();
            if (k == 3) en0_fb = 1'b0;
        end
        checks++;
        if (busy !== 1'b1 || sel_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: busy=%b sel_out=%b need 1 1", busy, sel_out);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({sel_out, cur_sel, busy, done, err, rif.req_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_mid: got sel/cur/busy/done/err/ready=%b need 000001", {sel_out, cur_sel, busy, done, err, rif.req_ready});
        end
        en0_fb = 1'b1;
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_fault();
        en1_fb = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 4) en1_fb = 1'b0;
            if (k == 2) begin
                checks++;
                if (fault !== 1'b0) begin
                    errors++;
                    $display("FAIL fault_early: fault=%b need 0", fault);
                end
            end
            if (k == 3) begin
                checks++;
                if (fault !== 1'b1) begin
                    errors++;
                    $display("FAIL fault_set: fault=%b need 1", fault);
                end
            end
        end
        checks++;
        if (fault !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fault_sticky: fault=%b busy=%b need 1 0", fault, busy);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: fault=%b need 0", fault);
        end
        repeat (4) tick();
    endtask

    task automatic test_timeout();
        int err_at = -1;
        int err_cnt = 0;
        int done_cnt = 0;
        logic cur_at_err = 1'b0;
        logic busy_at_err = 1'b1;
        logic busy_drop = 1'b0;
        rif.req_valid = 1'b1;
        rif.req_sel = 1'b1;
        tick();
        rif.req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) tick();
            if (k == 3) en0_fb = 1'b0;
            if (!busy) busy_drop = 1'b1;
            if (done) done_cnt++;
            if (err) begin
                err_cnt++;
                if (err_at < 0) begin
                    err_at = k;
                    cur_at_err = cur_sel;
                    busy_at_err = busy;
                end
            end
        end
`ifdef CLK_SW_TIMEOUT_EN
        checks++;
        if (err_at != 22 || err_cnt != 1) begin
            errors++;
            $display("FAIL timeout_err: err at %0d count %0d need at 22 count 1", err_at, err_cnt);
        end
        checks++;
        if (cur_at_err !== 1'b1 || busy_at_err !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL timeout_state: cur_sel=%b busy=%b dones=%0d need 1 0 0", cur_at_err, busy_at_err, done_cnt);
        end
`else
        checks++;
        if (busy_drop || err_cnt != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL no_timeout: busy_dropped=%b errs=%0d dones=%0d need 0 0 0", busy_drop, err_cnt, done_cnt);
        end
`endif
        rst_n = 1'b0;
        en0_fb = 1'b1;
        en1_fb = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_same_sel();
        test_switch();
        test_busy_ignore();
        test_reset_mid();
        test_fault();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
